// File: rtl/fib_sequencer_if.sv
// Request/handshake inputs and the four mux data buses plus select/flags of the Fibonacci sequencer.
// master = stimulus/consumer side, slave = the sequencer itself.
interface fib_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] n_terms;
    logic             out_ready;
    logic [1:0]       disp_sel;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] prev_term;
    logic [WIDTH-1:0] idx_bus;
    logic [WIDTH-1:0] status;
    logic [1:0]       sel;
    logic             term_valid;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (
        output start, n_terms, out_ready, disp_sel,
        input  term, prev_term, idx_bus, status, sel, term_valid, busy, done, overflow
    );

    modport slave (
        input  start, n_terms, out_ready, disp_sel,
        output term, prev_term, idx_bus, status, sel, term_valid, busy, done, overflow
    );
endinterface

// File: rtl/fib_sequencer.sv
// Emits F(0..n_terms-1) one term per accepted valid/ready handshake; stops early on WIDTH overflow.
// All outputs come from registers, so there is no combinational path from any input.
module fib_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    fib_sequencer_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       sel_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] idx_ext;
    logic [WIDTH-1:0] status_w;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            prev_q  <= '0;
            idx_q   <= '0;
            n_q     <= '0;
            ovf_q   <= 1'b0;
            sel_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            prev_q  <= prev_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            ovf_q   <= ovf_d;
            sel_q   <= bus.disp_sel;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        prev_d  = prev_q;
        idx_d   = idx_q;
        n_d     = n_q;
        ovf_d   = ovf_q;
        sum     = {1'b0, prev_q} + {1'b0, cur_q};
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ovf_d = 1'b0;
                    if (bus.n_terms != '0) begin
                        n_d     = bus.n_terms;
                        prev_d  = '0;
                        cur_d   = '0;
                        idx_d   = '0;
                        state_d = EMIT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (idx_q == n_q - CNT_W'(1)) begin
                        state_d = DONE;
                    end else if (cur_q == '0) begin
                        // F0 -> F1 cannot be produced by the add since prev+cur is 0 here
                        prev_d = cur_q;
                        cur_d  = WIDTH'(1);
                        idx_d  = idx_q + CNT_W'(1);
                    end else if (sum[WIDTH]) begin
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        prev_d = cur_q;
                        cur_d  = sum[WIDTH-1:0];
                        idx_d  = idx_q + CNT_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_ext              = '0;
        idx_ext[CNT_W-1:0]   = idx_q;
        status_w             = '0;
        status_w[3:0]        = {ovf_q, state_q == DONE, state_q == EMIT, state_q == EMIT};
    end

    assign bus.term       = cur_q;
    assign bus.prev_term  = prev_q;
    assign bus.idx_bus    = idx_ext;
    assign bus.status     = status_w;
    assign bus.sel        = sel_q;
    assign bus.term_valid = (state_q == EMIT);
    assign bus.busy       = (state_q == EMIT);
    assign bus.done       = (state_q == DONE);
    assign bus.overflow   = ovf_q;
endmodule
